sine_tone_sequencer: RTL and testbench

Sequencing controller for the 64-sample-per-period sine datapath. Holds a small programmable table of tone steps, each a sample-rate divider plus a duration in periods. Plays the steps in order and emits, per step:
- a one-clock sample strobe;
- the 6-bit phase index;
- quarter-wave ROM address and mirror/negate controls.

A downstream quarter-wave ROM and sign stage produce the sample.

---
 rtl/sine_tone_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sine_tone_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_tone_sequencer.sv
// sine_tone_sequencer: plays a programmable table of tone steps, each a
// sample-rate divider plus a duration in 64-sample periods. For each sample
// it emits a one-clock strobe, the 6-bit phase index and the quarter-wave
// ROM address with mirror/negate controls.
//
// Optional feature macro: SINE_SEQ_AMP_EN. When it is defined, each entry
// also stores an 8-bit amplitude (cfg_amp), which is presented on amp
// during LOAD/RUN.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_div/cfg_dur  table write port (IDLE only)
//   cfg_amp                       entry amplitude (SINE_SEQ_AMP_EN only)
//   start, stop, loop             sequence control
//   busy, done, step_idx          sequence status
//   sample_tick, phase            sample strobe and index 0..63
//   rom_addr, rom_mirror, rom_negate  quarter-wave ROM controls
//   amp                           step amplitude (SINE_SEQ_AMP_EN only)
module sine_tone_sequencer #(
    parameter int unsigned STEPS = 8,
    parameter int unsigned DIV_W = 24,
    parameter int unsigned DUR_W = 16,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DUR_W-1:0] cfg_dur,
`ifdef SINE_SEQ_AMP_EN
    input  logic [7:0]       cfg_amp,
    output logic [7:0]       amp,
`endif
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    step_idx,
    output logic             sample_tick,
    output logic [5:0]       phase,
    output logic [3:0]       rom_addr,
    output logic             rom_mirror,
    output logic             rom_negate
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [DIV_W-1:0] tbl_div [STEPS];
    logic [DUR_W-1:0] tbl_dur [STEPS];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    step_d, step_nx;
    logic [DIV_W-1:0] work_div_q, work_div_d, div_cnt_q, div_cnt_d;
    logic [DUR_W-1:0] work_dur_q, work_dur_d, per_cnt_q, per_cnt_d;
    logic [5:0]       phase_d;
    logic             busy_d, done_d, tick_d, last_step;
`ifdef SINE_SEQ_AMP_EN
    logic [7:0]       tbl_amp [STEPS];
    logic [7:0]       amp_d;
`endif

    // Step table; only writable while idle so a running sequence is stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_div[i] <= '0;
                tbl_dur[i] <= '0;
`ifdef SINE_SEQ_AMP_EN
                tbl_amp[i] <= '0;
`endif
            end
        end else if (cfg_we && state_q == S_IDLE) begin
            tbl_div[cfg_addr] <= cfg_div;
            tbl_dur[cfg_addr] <= cfg_dur;
`ifdef SINE_SEQ_AMP_EN
            tbl_amp[cfg_addr] <= cfg_amp;
`endif
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        step_d     = step_idx;
        phase_d    = phase;
        div_cnt_d  = div_cnt_q;
        per_cnt_d  = per_cnt_q;
        work_div_d = work_div_q;
        work_dur_d = work_dur_q;
        step_nx    = step_idx + AW'(1);
        // Sequence ends at the table end or at a zero-duration marker.
        last_step  = (step_idx == AW'(STEPS - 1)) || (tbl_dur[step_nx] == '0);

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                end
            end
            S_LOAD: begin
                work_div_d = tbl_div[step_idx];
                work_dur_d = tbl_dur[step_idx];
                div_cnt_d  = '0;
                per_cnt_d  = '0;
                phase_d    = '0;
                if (tbl_dur[step_idx] == '0) begin
                    // A marker at entry 0 would loop forever; treat as end.
                    if (step_idx == '0 || !loop) begin
                        state_d = S_DONE;
                    end else begin
                        step_d = '0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (div_cnt_q == work_div_q) begin
                    div_cnt_d = '0;
                    phase_d   = phase + 6'd1;
                    if (phase == 6'd63) begin
                        per_cnt_d = per_cnt_q + DUR_W'(1);
                        if (per_cnt_d == work_dur_q) begin
                            if (!last_step) begin
                                state_d = S_LOAD;
                                step_d  = step_nx;
                            end else if (loop) begin
                                state_d = S_LOAD;
                                step_d  = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: back to idle with the sample path quiet and no done pulse.
        if (stop && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            phase_d   = '0;
            div_cnt_d = '0;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        tick_d = (state_d == S_RUN) && (div_cnt_d == work_div_d);

`ifdef SINE_SEQ_AMP_EN
        amp_d = '0;
        if (state_d == S_RUN) begin
            amp_d = (state_q == S_LOAD) ? tbl_amp[step_idx] : amp;
        end else if (state_d == S_LOAD && state_q != S_IDLE) begin
            amp_d = amp;
        end
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            step_idx    <= '0;
            phase       <= '0;
            div_cnt_q   <= '0;
            per_cnt_q   <= '0;
            work_div_q  <= '0;
            work_dur_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_tick <= 1'b0;
            rom_addr    <= '0;
            rom_mirror  <= 1'b0;
            rom_negate  <= 1'b0;
`ifdef SINE_SEQ_AMP_EN
            amp         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_idx    <= step_d;
            phase       <= phase_d;
            div_cnt_q   <= div_cnt_d;
            per_cnt_q   <= per_cnt_d;
            work_div_q  <= work_div_d;
            work_dur_q  <= work_dur_d;
            busy        <= busy_d;
            done        <= done_d;
            sample_tick <= tick_d;
            // Second and fourth quadrants read the quarter-wave backwards.
            rom_addr    <= phase_d[4] ? ~phase_d[3:0] : phase_d[3:0];
            rom_mirror  <= phase_d[4];
            rom_negate  <= phase_d[5];
`ifdef SINE_SEQ_AMP_EN
            amp         <= amp_d;
`endif
        end
    end

endmodule

// File: tb/tb_sine_tone_sequencer.sv
// Self-checking bench for sine_tone_sequencer: stimulus pushes expected
// sample/done events into a queue; a negedge monitor pops and compares them.
module tb_sine_tone_sequencer;

    localparam int unsigned STEPS = 8;
    localparam int unsigned DIV_W = 24;
    localparam int unsigned DUR_W = 16;
    localparam int unsigned AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [DUR_W-1:0] cfg_dur = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop = 1'b0;
    logic             busy, done, sample_tick, rom_mirror, rom_negate;
    logic [AW-1:0]    step_idx;
    logic [5:0]       phase;
    logic [3:0]       rom_addr;

    sine_tone_sequencer #(.STEPS(STEPS), .DIV_W(DIV_W), .DUR_W(DUR_W), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div), .cfg_dur(cfg_dur),
        .start(start), .stop(stop), .loop(loop),
        .busy(busy), .done(done), .step_idx(step_idx),
        .sample_tick(sample_tick), .phase(phase),
        .rom_addr(rom_addr), .rom_mirror(rom_mirror), .rom_negate(rom_negate)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit is_done;
        int cyc;
        int step;
        int ph;
    } exp_t;

    exp_t sb[$];
    int   tb_div[STEPS];
    int   tb_dur[STEPS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void push_tick(input int c, input int s, input int p);
        exp_t e;
        e.is_done = 1'b0; e.cyc = c; e.step = s; e.ph = p;
        sb.push_back(e);
    endfunction

    function automatic void push_done(input int c, input int s);
        exp_t e;
        e.is_done = 1'b1; e.cyc = c; e.step = s; e.ph = 0;
        sb.push_back(e);
    endfunction

    // Expected events for a non-looping run started in cycle s.
    function automatic void push_seq(input int s);
        int t;
        int rs;
        t = s + 1;
        if (tb_dur[0] == 0) begin
            push_done(t + 1, 0);
            return;
        end
        for (int idx = 0; idx < STEPS; idx++) begin
            rs = t + 1;
            for (int k = 0; k < 64 * tb_dur[idx]; k++)
                push_tick(rs + tb_div[idx] + (tb_div[idx] + 1) * k, idx, k % 64);
            t = rs + 64 * tb_dur[idx] * (tb_div[idx] + 1);
            if (idx == STEPS - 1 || tb_dur[idx + 1] == 0) begin
                push_done(t, idx);
                return;
            end
        end
    endfunction

    // Monitor: every strobe or done pulse must match the head of the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   q, a;
        if (reset_n && (sample_tick === 1'b1 || done === 1'b1)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event @cyc %0d: got tick=%b done=%b expected none",
                         cyc, sample_tick, done);
            end else begin
                e = sb.pop_front();
                if (e.is_done) begin
                    check("done_event",
                          64'({32'(cyc), done, sample_tick, busy, 8'(step_idx)}),
                          64'({32'(e.cyc), 1'b1, 1'b0, 1'b0, 8'(e.step)}));
                end else begin
                    q = (e.ph / 16) % 2;
                    a = (q == 1) ? 15 - (e.ph % 16) : e.ph % 16;
                    check("tick_event",
                          64'({32'(cyc), sample_tick, done, 8'(step_idx), 8'(phase),
                               4'(rom_addr), rom_mirror, rom_negate}),
                          64'({32'(e.cyc), 1'b1, 1'b0, 8'(e.step), 8'(e.ph),
                               4'(a), 1'(q), 1'(e.ph / 32)}));
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int addr, input int dv, input int dr, input bit idle);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_div  = DIV_W'(dv);
        cfg_dur  = DUR_W'(dr);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (idle) begin
            tb_div[addr] = dv;
            tb_dur[addr] = dr;
        end
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        n = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < STEPS; i++) begin
            tb_div[i] = 0;
            tb_dur[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({busy, done, sample_tick, step_idx, phase, rom_addr, rom_mirror, rom_negate}), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1/2: single step div=3 dur=1, plus ROM decode spot checks.
        cfg_write(0, 3, 1, 1'b1);
        cfg_write(1, 0, 0, 1'b1);
        pulse_start(n);
        push_seq(n);
        check("t1_busy_load", 64'({busy, sample_tick, phase}), 64'({1'b1, 1'b0, 6'd0}));
        wait_cyc(n + 85);
        check("t2_phase20", 64'({phase, rom_addr, rom_mirror, rom_negate}),
              64'({6'd20, 4'd11, 1'b1, 1'b0}));
        wait_cyc(n + 153);
        check("t2_phase37", 64'({phase, rom_addr, rom_mirror, rom_negate}),
              64'({6'd37, 4'd5, 1'b0, 1'b1}));
        wait_cyc(n + 258);
        check("t1_done_cycle", 64'({done, busy}), 64'({1'b1, 1'b0}));
        wait_cyc(n + 260);
        check("t1_idle_after", 64'({done, busy}), 64'd0);

        // 3: three steps with different dividers.
        cfg_write(0, 1, 1, 1'b1);
        cfg_write(1, 0, 2, 1'b1);
        cfg_write(2, 2, 1, 1'b1);
        cfg_write(3, 0, 0, 1'b1);
        pulse_start(n);
        push_seq(n);
        wait_cyc(n + 130);
        check("t3_load_gap1", 64'({busy, sample_tick, 8'(step_idx), phase}),
              64'({1'b1, 1'b0, 8'd1, 6'd0}));
        wait_cyc(n + 259);
        check("t3_load_gap2", 64'({busy, sample_tick, 8'(step_idx)}),
              64'({1'b1, 1'b0, 8'd2}));
        wait_cyc(n + 455);

        // 4: looping, then abort.
        cfg_write(0, 0, 1, 1'b1);
        cfg_write(1, 0, 0, 1'b1);
        loop = 1'b1;
        pulse_start(n);
        for (int k = 0; k < 64; k++) push_tick(n + 2 + k, 0, k);
        for (int k = 0; k <= 10; k++) push_tick(n + 67 + k, 0, k);
        wait_cyc(n + 66);
        check("t4_loop_reload", 64'({busy, sample_tick, 8'(step_idx), phase}),
              64'({1'b1, 1'b0, 8'd0, 6'd0}));
        wait_cyc(n + 77);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        loop = 1'b0;
        check("t4_stop", 64'({busy, sample_tick, done, phase}), 64'd0);
        wait_cyc(n + 82);

        // 5: empty sequence.
        cfg_write(0, 5, 0, 1'b1);
        pulse_start(n);
        push_seq(n);
        wait_cyc(n + 6);

        // 6a: reset mid-run clears outputs and the table.
        cfg_write(0, 0, 2, 1'b1);
        pulse_start(n);
        for (int k = 0; k <= 18; k++) push_tick(n + 2 + k, 0, k);
        wait_cyc(n + 21);
        reset_n = 1'b0;
        #1;
        check("t6_async_reset",
              64'({busy, done, sample_tick, step_idx, phase, rom_addr, rom_mirror, rom_negate}), 64'd0);
        check("t6_sb_drained_at_reset", 64'(sb.size()), 64'd0);
        for (int i = 0; i < STEPS; i++) begin
            tb_div[i] = 0;
            tb_dur[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(n);
        push_seq(n);
        wait_cyc(n + 5);

        // 6b: start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check("t6_start_stop_idle", 64'({busy, done, sample_tick}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_start_stop_stay", 64'({busy, done, sample_tick}), 64'd0);

        // 6c: write while busy must not extend the sequence.
        cfg_write(0, 1, 1, 1'b1);
        pulse_start(n);
        push_seq(n);
        wait_cyc(n + 5);
        cfg_write(1, 0, 3, 1'b0);
        wait_cyc(n + 135);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
